// File: rtl/ysyx_23060201_lsu.sv
// ysyx_23060201_lsu: single-outstanding load/store unit with word-aligned bus requests and an optional LSU_TIMEOUT_EN wait timeout
module ysyx_23060201_lsu #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wen,
  input  logic [MEM_ADDR_WIDTH-1:0] req_waddr,
  input  logic [7:0]                req_wmask,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic                      req_ren,
  input  logic [MEM_ADDR_WIDTH-1:0] req_raddr,
  input  logic [7:0]                req_rmask,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [3:0]                mem_req_wstrb,
  output logic [DATA_WIDTH-1:0]     mem_req_wdata,
  input  logic                      mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_resp_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic wen_q, wen_d, sign_q, sign_d, err_q, err_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic timeout;
  assign timeout = cnt_q == 8'(TIMEOUT_CYCLES);
`endif
  logic [MEM_ADDR_WIDTH-1:0] in_addr;
  logic [3:0] in_mask;
  logic size_ok, misal, legal;
  logic [4:0] sh_amt;
  logic [DATA_WIDTH-1:0] shifted, load_data;
  logic unused;
  assign unused = ^{req_wmask[7:4], req_rmask[7:5], 32'(TIMEOUT_CYCLES)};
  assign in_addr = req_wen ? req_waddr : req_raddr;
  assign in_mask = req_wen ? req_wmask[3:0] : req_rmask[3:0];
  assign size_ok = in_mask == 4'b0001 || in_mask == 4'b0011 || in_mask == 4'b1111;
  assign misal = (in_mask == 4'b0011 && in_addr[0]) || (in_mask == 4'b1111 && |in_addr[1:0]);
  assign legal = size_ok && !misal;
  assign sh_amt = {addr_q[1:0], 3'b000};
  assign shifted = mem_resp_rdata >> sh_amt;
  assign load_data = mask_q == 4'b0001 ? {{(DATA_WIDTH-8){sign_q & shifted[7]}}, shifted[7:0]} :
                     mask_q == 4'b0011 ? {{(DATA_WIDTH-16){sign_q & shifted[15]}}, shifted[15:0]} : shifted;
  assign req_ready = state_q == IDLE;
  assign mem_req_valid = state_q == REQ;
  assign mem_req_wen = mem_req_valid & wen_q;
  assign mem_req_addr = mem_req_valid ? {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_req_wstrb = mem_req_valid ? mask_q << addr_q[1:0] : 4'b0000;
  assign mem_req_wdata = mem_req_valid ? wdata_q << sh_amt : '0;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err = resp_valid & err_q;
  // next-state and latched-request logic; illegal or null requests skip the bus
  always_comb begin
    state_d = state_q;
    wen_d = wen_q;
    addr_d = addr_q;
    mask_d = mask_q;
    sign_d = sign_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        wen_d = req_wen;
        addr_d = in_addr;
        mask_d = in_mask;
        sign_d = req_rmask[4];
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d = (req_wen & req_ren) | ((req_wen | req_ren) & !legal);
        state_d = (req_wen ^ req_ren) && legal ? REQ : RESP;
`ifdef LSU_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      REQ: begin
`ifdef LSU_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
        if (!mem_req_ready && timeout) begin
          state_d = RESP;
          err_d = 1'b1;
        end
`endif
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
`ifdef LSU_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
        if (!mem_resp_valid && timeout) begin
          state_d = RESP;
          err_d = 1'b1;
        end
`endif
        if (mem_resp_valid) begin
          state_d = RESP;
          rdata_d = wen_q ? '0 : load_data;
        end
      end
      default: if (resp_ready) state_d = IDLE;
    endcase
  end
  // state and request registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wen_q <= 1'b0;
      addr_q <= '0;
      mask_q <= '0;
      sign_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      mask_q <= mask_d;
      sign_q <= sign_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// tb_ysyx_23060201_lsu: directed plus randomized checks of the LSU against a byte-arithmetic reference model
module tb_ysyx_23060201_lsu;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_wen = 0, req_ren = 0;
  logic [31:0] req_waddr = 0, req_raddr = 0, req_wdata = 0;
  logic [7:0] req_wmask = 0, req_rmask = 0;
  logic resp_valid, resp_ready = 0, resp_err;
  logic [31:0] resp_rdata;
  logic mem_req_valid, mem_req_ready = 0, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0] mem_req_wstrb;
  logic mem_resp_valid = 0;
  logic [31:0] mem_resp_rdata = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  ysyx_23060201_lsu dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_waddr(req_waddr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .req_ren(req_ren), .req_raddr(req_raddr), .req_rmask(req_rmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic wen, input logic ren, input logic [31:0] addr, input logic [7:0] mask,
                     input logic [31:0] wd, input logic [31:0] word, input int rdy_dly, input int resp_dly, input int cons_dly);
    int off, nb;
    bit e, bus;
    longint v, pw;
    logic [63:0] wsh;
    logic [31:0] exp_rdata;
    logic [3:0] exp_strb;
    off = int'(addr % 4);
    nb = mask[3:0] == 4'h1 ? 1 : mask[3:0] == 4'h3 ? 2 : mask[3:0] == 4'hF ? 4 : 0;
    if (wen && ren) e = 1;
    else if (!wen && !ren) e = 0;
    else if (nb == 0) e = 1;
    else e = (addr % nb) != 0;
    bus = (wen ^ ren) && !e;
    v = 0;
    if (bus && ren) begin
      pw = longint'(1) << (8 * nb);
      v = (longint'(word) / (longint'(1) << (8 * off))) % pw;
      if (mask[4] && nb < 4 && v >= pw / 2) v = v - pw;
    end
    exp_rdata = v[31:0];
    exp_strb = 4'((int'(mask[3:0]) * (1 << off)) % 16);
    wsh = 64'(wd) << (8 * off);
    @(negedge clk);
    req_valid = 1; req_wen = wen; req_ren = ren; req_wdata = wd;
    req_waddr = wen ? addr : $urandom; req_raddr = ren ? addr : $urandom;
    req_wmask = wen ? mask : 8'($urandom); req_rmask = ren ? mask : 8'($urandom);
    chk("idle_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0; req_wen = 0; req_ren = 0;
    if (bus) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        chk("mem_req_valid", mem_req_valid, 1);
        chk("mem_req_addr", mem_req_addr, {addr[31:2], 2'b00});
        chk("mem_req_wen", mem_req_wen, wen);
        chk("mem_req_wstrb", mem_req_wstrb, exp_strb);
        if (wen) chk("mem_req_wdata", mem_req_wdata, wsh[31:0]);
        chk("busy_req_ready", req_ready, 0);
        chk("early_resp_valid", resp_valid, 0);
        mem_resp_valid = 1'($urandom); mem_resp_rdata = $urandom;
        if (i == rdy_dly) mem_req_ready = 1;
        @(negedge clk);
      end
      mem_req_ready = 0; mem_resp_valid = 0;
      for (int i = 0; i <= resp_dly; i++) begin
        chk("wait_no_req", mem_req_valid, 0);
        if (i == resp_dly) begin mem_resp_valid = 1; mem_resp_rdata = word; end
        @(negedge clk);
      end
      mem_resp_valid = 0; mem_resp_rdata = $urandom;
    end else chk("no_bus_access", mem_req_valid, 0);
    for (int i = 0; i <= cons_dly; i++) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", resp_err, e);
      chk("resp_req_ready", req_ready, 0);
      if (i == cons_dly) resp_ready = 1;
      @(negedge clk);
    end
    resp_ready = 0;
    chk("resp_done", resp_valid, 0);
    chk("back_idle", req_ready, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    rst_n = 1;
    run(0, 1, 32'h8000_0003, 8'h11, 32'h0, 32'h80AB_CDEF, 0, 0, 0);
    run(0, 1, 32'h8000_0002, 8'h03, 32'h0, 32'h8001_1234, 0, 0, 0);
    run(1, 0, 32'h8000_0002, 8'h03, 32'h0000_BEEF, 32'hDEAD_BEEF, 0, 0, 0);
    run(1, 0, 32'h8000_0001, 8'h0F, 32'h1234_5678, 32'h0, 0, 0, 0);
    run(0, 1, 32'h8000_0004, 8'h0F, 32'h0, 32'hCAFE_F00D, 5, 2, 3);
    run(0, 0, 32'h8000_0000, 8'h0F, 32'h0, 32'h0, 0, 0, 0);
    run(1, 1, 32'h8000_0000, 8'h0F, 32'h0, 32'h0, 0, 0, 0);
    run(0, 1, 32'h8000_0000, 8'h07, 32'h0, 32'h0, 0, 0, 0);
    run(0, 1, 32'h8000_0001, 8'h13, 32'h0, 32'h0, 0, 0, 1);
    run(0, 1, 32'h8000_0002, 8'h13, 32'h0, 32'h8001_1234, 0, 1, 0);
    @(negedge clk);
    req_valid = 1; req_ren = 1; req_raddr = 32'h8000_0000; req_rmask = 8'h0F;
    @(negedge clk);
    req_valid = 0; req_ren = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h1111_2222;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    @(negedge clk);
    mem_resp_valid = 0;
    chk("stale_resp_valid", resp_valid, 0);
    chk("stale_req_ready", req_ready, 1);
    chk("stale_mem_req_valid", mem_req_valid, 0);
    for (int n = 0; n < 60; n++) begin
      int k;
      logic [7:0] m;
      logic w, r;
      k = int'($urandom_range(0, 9));
      w = k < 4; r = k >= 4 && k < 8;
      if (k == 8) begin w = 1; r = 1; end
      m = k == 9 ? 8'h0F : ($urandom_range(0, 7) == 0 ? 8'h05 : (8'h01 << (2 * $urandom_range(0, 2))) - 8'h01);
      m = m == 8'h0F ? m : (m == 8'h00 ? 8'h01 : (m == 8'h03 ? 8'h03 : m));
      m = m | (8'($urandom_range(0, 1)) << 4);
      run(w, r, $urandom, m, $urandom, $urandom,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
`ifdef LSU_TIMEOUT_EN
    begin
      int cyc;
      @(negedge clk);
      req_valid = 1; req_ren = 1; req_raddr = 32'h8000_0008; req_rmask = 8'h0F;
      @(negedge clk);
      req_valid = 0; req_ren = 0; mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      cyc = 0;
      while (!resp_valid && cyc < 400) begin @(negedge clk); cyc++; end
      chk("timeout_seen", resp_valid, 1);
      chk("timeout_window", 32'(cyc >= 250 && cyc < 300), 1);
      chk("timeout_err", resp_err, 1);
      chk("timeout_rdata", resp_rdata, 0);
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h5555_AAAA;
      @(negedge clk);
      mem_resp_valid = 0;
      chk("late_resp_ignored", resp_valid, 0);
      chk("late_req_ready", req_ready, 1);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
